// File: rtl/i2so_serializer_pkg.sv
// i2so_serializer_pkg: constants and helpers shared by the I2S transmit path.
// Holds the slot geometry (16-bit channels, 32 slots per frame), the
// word-select encoding and a helper that maps a slot index to its WS level.
package i2so_serializer_pkg;

    localparam int unsigned I2S_WIDTH  = 16;
    localparam int unsigned I2S_SLOTS  = 32;
    localparam int unsigned I2S_SLOT_W = $clog2(I2S_SLOTS);

    localparam logic I2S_WS_LEFT  = 1'b0;
    localparam logic I2S_WS_RIGHT = 1'b1;

    typedef logic [I2S_SLOT_W-1:0] slot_t;

    localparam slot_t I2S_LAST_SLOT = slot_t'(I2S_SLOTS - 1);

    // WS switches one slot ahead of the channel it announces: slots 15..30
    // are right, slot 31 and slots 0..14 are left.
    function automatic logic ws_for_slot(input slot_t s);
        return ((s >= slot_t'(15)) && (s <= slot_t'(30))) ? I2S_WS_RIGHT : I2S_WS_LEFT;
    endfunction

endpackage

// File: rtl/i2so_serializer_if.sv
// i2so_serializer_if: bundle of control, sample-load and I2S output signals.
//   rf_i2so_en            transmitter enable
//   i2so_ld               load strobe for i2so_lft / i2so_rgt
//   i2so_lft, i2so_rgt    left / right sample
//   i2so_sck, i2so_ws,
//   i2so_sd               I2S bit clock, word select, serial data
//   i2so_xfc, i2so_ufl    buffer-consumed and underflow pulses
// Modport master is the serializer (drives the I2S pins); slave is the side
// feeding samples and observing the bus.
interface i2so_serializer_if
    import i2so_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = I2S_WIDTH
);
    logic             rf_i2so_en;
    logic             i2so_ld;
    logic [WIDTH-1:0] i2so_lft;
    logic [WIDTH-1:0] i2so_rgt;
    logic             i2so_sck;
    logic             i2so_ws;
    logic             i2so_sd;
    logic             i2so_xfc;
    logic             i2so_ufl;

    modport master (
        input  rf_i2so_en, i2so_ld, i2so_lft, i2so_rgt,
        output i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ufl
    );

    modport slave (
        output rf_i2so_en, i2so_ld, i2so_lft, i2so_rgt,
        input  i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ufl
    );

endinterface

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen: bit-clock generator. Divides clk by 2*DIV and flags the clk in
// which sck falls so a shifter can advance in lockstep.
//   clk   master clock
//   rst   asynchronous active-low reset
//   en    run enable; low forces sck low and restarts the divider
//   sck   registered bit clock
//   fall  strobe, high in the clk whose edge takes sck from 1 to 0
module i2s_sck_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == DIV_LAST);
    assign fall = en && wrap && sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2so_serializer.sv
// i2so_serializer: I2S master transmitter. Generates sck/ws and shifts a
// 16-bit left then right sample MSB-first on sd, one sck after each WS edge.
// Samples are taken from a single-entry holding buffer at each frame start.
//   clk   master clock
//   rst   asynchronous active-low reset
//   bus   i2so_serializer_if.master: rf_i2so_en, i2so_ld, i2so_lft, i2so_rgt
//         in; i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ufl out (registered)
module i2so_serializer
    import i2so_serializer_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned WIDTH = I2S_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    i2so_serializer_if.master   bus
);

    logic [WIDTH-1:0]   hold_l;
    logic [WIDTH-1:0]   hold_r;
    logic               pending;
    slot_t              slot;
    slot_t              slot_nxt;
    logic [2*WIDTH-1:0] shift;
    logic               ws;
    logic               sd;
    logic               xfc;
    logic               ufl;
    logic               sck;
    logic               fall;
    logic               frame_start;

    i2s_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.rf_i2so_en),
        .sck  (sck),
        .fall (fall)
    );

    assign slot_nxt    = slot + 1'b1;
    assign frame_start = fall && (slot_nxt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_l  <= '0;
            hold_r  <= '0;
            pending <= 1'b0;
            slot    <= I2S_LAST_SLOT;
            shift   <= '0;
            ws      <= I2S_WS_LEFT;
            sd      <= 1'b0;
            xfc     <= 1'b0;
            ufl     <= 1'b0;
        end else begin
            if (!bus.rf_i2so_en) begin
                // Parking at the last slot makes the next fall a frame start.
                slot <= I2S_LAST_SLOT;
                ws   <= I2S_WS_LEFT;
                sd   <= 1'b0;
                xfc  <= 1'b0;
                ufl  <= 1'b0;
            end else begin
                xfc <= 1'b0;
                ufl <= 1'b0;
                if (fall) begin
                    slot <= slot_nxt;
                    ws   <= ws_for_slot(slot_nxt);
                    if (frame_start) begin
                        shift <= {hold_l, hold_r};
                        sd    <= hold_l[WIDTH-1];
                        xfc   <= 1'b1;
                        ufl   <= !pending;
                    end else begin
                        sd    <= shift[2*WIDTH-2];
                        shift <= shift << 1;
                    end
                end
            end

            // A load landing on a frame start refills the buffer after the
            // frame has taken the old contents, so pending stays set.
            if (bus.i2so_ld) begin
                hold_l  <= bus.i2so_lft;
                hold_r  <= bus.i2so_rgt;
                pending <= 1'b1;
            end else if (bus.rf_i2so_en && frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.i2so_sck = sck;
    assign bus.i2so_ws  = ws;
    assign bus.i2so_sd  = sd;
    assign bus.i2so_xfc = xfc;
    assign bus.i2so_ufl = ufl;

endmodule

// File: tb/tb_i2so_serializer.sv
// tb_i2so_serializer: two serializers (DIV=2 and DIV=1) share one stimulus
// stream. An arithmetic model derives every output from the count of enabled
// clk edges; directed sequences pin literal frame contents and timing.
module tb_i2so_serializer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ld;
    logic [15:0] lft;
    logic [15:0] rgt;

    int n_tests = 0;
    int n_fail  = 0;

    i2so_serializer_if #(.WIDTH(16)) if2 ();
    i2so_serializer_if #(.WIDTH(16)) if1 ();

    assign if2.rf_i2so_en = en;
    assign if2.i2so_ld    = ld;
    assign if2.i2so_lft   = lft;
    assign if2.i2so_rgt   = rgt;
    assign if1.rf_i2so_en = en;
    assign if1.i2so_ld    = ld;
    assign if1.i2so_lft   = lft;
    assign if1.i2so_rgt   = rgt;

    i2so_serializer #(.DIV(2), .WIDTH(16)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    i2so_serializer #(.DIV(1), .WIDTH(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t_m: enabled clk edges since enable/reset. Fall k (k>=1) happens at
    // edge 2*DIV*k and opens slot (k-1) mod 32.
    int          t_m[2]     = '{0, 0};
    bit          pend_m[2]  = '{0, 0};
    logic [31:0] frame_m[2] = '{32'h0, 32'h0};
    bit          xfc_m[2]   = '{0, 0};
    bit          ufl_m[2]   = '{0, 0};
    logic [15:0] hl_m = '0;
    logic [15:0] hr_m = '0;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                t_m[i]     <= 0;
                pend_m[i]  <= 1'b0;
                frame_m[i] <= '0;
                xfc_m[i]   <= 1'b0;
                ufl_m[i]   <= 1'b0;
            end
            hl_m <= '0;
            hr_m <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  nt;
                bit  fs;
                nt = en ? t_m[i] + 1 : 0;
                fs = en && (nt % (2 * div_of(i)) == 0) && (((nt / (2 * div_of(i))) - 1) % 32 == 0);
                t_m[i]   <= nt;
                xfc_m[i] <= fs;
                ufl_m[i] <= fs && !pend_m[i];
                if (fs) frame_m[i] <= {hl_m, hr_m};
                pend_m[i] <= ld ? 1'b1 : (fs ? 1'b0 : pend_m[i]);
            end
            if (ld) begin
                hl_m <= lft;
                hr_m <= rgt;
            end
        end
    end

    // {sck, ws, sd, xfc, ufl}
    function automatic logic [4:0] model_out(input int i);
        int   n, d, f, s;
        logic sck_e, ws_e, sd_e;
        n     = t_m[i];
        d     = div_of(i);
        f     = n / (2 * d);
        sck_e = ((n / d) % 2) == 1;
        ws_e  = 1'b0;
        sd_e  = 1'b0;
        if (f > 0) begin
            s    = (f - 1) % 32;
            ws_e = (s >= 15) && (s <= 30);
            sd_e = frame_m[i][31 - s];
        end
        return {sck_e, ws_e, sd_e, xfc_m[i], ufl_m[i]};
    endfunction

    always @(negedge clk) begin
        check("out_div2", {27'd0, if2.i2so_sck, if2.i2so_ws, if2.i2so_sd, if2.i2so_xfc,
              if2.i2so_ufl}, {27'd0, model_out(0)});
        check("out_div1", {27'd0, if1.i2so_sck, if1.i2so_ws, if1.i2so_sd, if1.i2so_xfc,
              if1.i2so_ufl}, {27'd0, model_out(1)});
    end

    // ---------------- DIV=1 literal timing ----------------
    int en_cnt  = 0;
    int xfc1_n  = 0;

    always @(posedge clk) begin
        if (en) en_cnt <= en_cnt + 1;
    end

    always @(negedge clk) begin
        if (if1.i2so_xfc && xfc1_n < 2) begin
            xfc1_n <= xfc1_n + 1;
            if (xfc1_n == 0) check("div1_first_xfc_clk", en_cnt, 2);
            else             check("div1_second_xfc_clk", en_cnt, 66);
        end
    end

    // ---------------- directed helpers (DIV=2 instance) ----------------
    task automatic wait_xfc(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!if2.i2so_xfc && cnt < 40);
        @(negedge clk);
    endtask

    // Caller sits on the negedge where xfc is visible (slot 0); returns on
    // the negedge of slot 31.
    task automatic grab(output logic [31:0] bits, output logic [31:0] wsb, output logic ufl0);
        ufl0 = if2.i2so_ufl;
        for (int s = 0; s < 32; s++) begin
            bits[31 - s] = if2.i2so_sd;
            wsb[31 - s]  = if2.i2so_ws;
            if (s < 31) repeat (4) @(negedge clk);
        end
    endtask

    logic [31:0] bits, wsb;
    logic        ufl0;
    int          cnt;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        ld  = 1'b0;
        lft = '0;
        rgt = '0;
        #3 rst = 1'b0;
        #1;
        check("reset_outputs", {27'd0, if2.i2so_sck, if2.i2so_ws, if2.i2so_sd, if2.i2so_xfc,
              if2.i2so_ufl}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Frame 1: fresh load.
        @(negedge clk);
        #1 ld = 1'b1; lft = 16'hA5F0; rgt = 16'h0F3C;
        @(negedge clk);
        #1 ld = 1'b0; en = 1'b1;
        wait_xfc(cnt);
        check("first_xfc_clk", cnt, 4);
        grab(bits, wsb, ufl0);
        check("frame1_ufl", {31'd0, ufl0}, 32'd0);
        check("frame1_bits", bits, 32'hA5F0_0F3C);
        check("frame1_ws", wsb, 32'h0001_FFFE);

        // Frame 2: no load, underflow repeat.
        repeat (4) @(negedge clk);
        check("second_xfc_at_128", {31'd0, if2.i2so_xfc}, 32'd1);
        grab(bits, wsb, ufl0);
        check("frame2_ufl", {31'd0, ufl0}, 32'd1);
        check("frame2_bits", bits, 32'hA5F0_0F3C);

        // Frame 3: load coincident with the frame-start edge.
        repeat (3) @(posedge clk);
        #2 ld = 1'b1; lft = 16'h8001; rgt = 16'h7FFE;
        @(posedge clk);
        #2 ld = 1'b0;
        @(negedge clk);
        check("frame3_xfc", {31'd0, if2.i2so_xfc}, 32'd1);
        grab(bits, wsb, ufl0);
        check("frame3_ufl", {31'd0, ufl0}, 32'd1);
        check("frame3_old_bits", bits, 32'hA5F0_0F3C);

        // Frame 4: the coincident load is now transmitted.
        repeat (4) @(negedge clk);
        grab(bits, wsb, ufl0);
        check("frame4_ufl", {31'd0, ufl0}, 32'd0);
        check("frame4_bits", bits, 32'h8001_7FFE);

        // Disable at slot 7 of frame 5.
        repeat (4) @(negedge clk);
        repeat (28) @(negedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("disabled_pins", {29'd0, if2.i2so_sck, if2.i2so_ws, if2.i2so_sd}, 32'd0);
        end
        #1 en = 1'b1;
        wait_xfc(cnt);
        check("reenable_xfc_clk", cnt, 4);
        grab(bits, wsb, ufl0);
        check("restart_ufl", {31'd0, ufl0}, 32'd1);
        check("restart_bits", bits, 32'h8001_7FFE);

        // Reset at slot 20.
        repeat (4) @(negedge clk);
        repeat (80) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_reset_div2", {27'd0, if2.i2so_sck, if2.i2so_ws, if2.i2so_sd,
              if2.i2so_xfc, if2.i2so_ufl}, 32'd0);
        check("async_reset_div1", {27'd0, if1.i2so_sck, if1.i2so_ws, if1.i2so_sd,
              if1.i2so_xfc, if1.i2so_ufl}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        wait_xfc(cnt);
        check("post_reset_xfc_clk", cnt, 4);
        grab(bits, wsb, ufl0);
        check("post_reset_ufl", {31'd0, ufl0}, 32'd1);
        check("post_reset_bits", bits, 32'h0000_0000);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            ld  = ($urandom % 50) == 0;
            lft = 16'($urandom);
            rgt = 16'($urandom);
            if (en && ($urandom % 600) == 0) en = 1'b0;
            else if (!en && ($urandom % 15) == 0) en = 1'b1;
            if (($urandom % 1500) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        ld = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2so_serializer.md
Name: i2so_serializer

Overview:
- I2S master transmitter; the output-direction counterpart of the I2S input deserializer in the audio path.
- Generates the bit clock (i2so_sck) and word select (i2so_ws) from clk, and shifts out 16-bit left/right samples MSB-first on i2so_sd in standard I2S framing (1-bit delay after the WS edge).
- Samples come from a register-file enable and a single-entry holding buffer loaded by the upstream audio datapath.

Parameters:
- DIV, 4: clk cycles per sck half-period; must be >= 1. sck period is 2*DIV clk.
- WIDTH, 16: bits per channel slot. Fixed at 16 in this revision; frame length is 2*WIDTH sck periods.

Ports:
- clk  in  1  master clock
- rst  in  1  reset, asynchronous, active-low
- rf_i2so_en  in  1  transmitter enable from register file
- i2so_ld  in  1  load strobe; captures i2so_lft/i2so_rgt this cycle
- i2so_lft  in  16  left sample to transmit
- i2so_rgt  in  16  right sample to transmit
- i2so_sck  out  1  I2S bit clock (registered)
- i2so_ws  out  1  word select: 0 = left, 1 = right (registered)
- i2so_sd  out  1  serial data (registered)
- i2so_xfc  out  1  1-clk pulse: holding buffer consumed at frame start
- i2so_ufl  out  1  1-clk pulse: frame started with no new load (underflow)

Behaviour:
- Reset and idle values:
  - Reset: all outputs 0; hold_l/hold_r = 0; pending = 0; div_cnt = 0; slot = 31; shift = 0.
  - rf_i2so_en = 0 (checked every clk, overrides all else): sck, ws, sd forced 0; div_cnt = 0; slot = 31; xfc/ufl = 0.
  - Hold registers and pending are not cleared by disable.
- Divider:
  - When enabled, div_cnt counts 0..DIV-1.
  - At DIV-1, div_cnt wraps and sck toggles.
  - A 1->0 toggle is a "fall event", acted on in the same clk.
- Fall event, slot increments mod 32:
  - New slot = 0 (frame start):
    - shift <= {hold_l, hold_r}; sd <= hold_l[15].
    - xfc <= 1.
    - ufl <= !pending; pending <= 0.
  - Otherwise: sd <= shift[30]; shift <= shift << 1.
  - ws for the new slot c: ws = 1 for c in 15..30; ws = 0 for c = 31 and c in 0..14. WS therefore leads its channel's MSB by one sck.
- Net frame timing:
  - Slots 0-15 carry left MSB..LSB; slots 16-31 carry right MSB..LSB.
  - Frame period = 64*DIV clk.
- Startup latency: after en rises (from idle), the first sck rise is at clk DIV and the first fall (frame start, xfc) at clk 2*DIV.
- Load:
  - When i2so_ld = 1, hold_l/hold_r capture the inputs and pending <= 1.
  - Loads are accepted whether enabled or not.
  - Load coincident with frame start: the frame uses the old hold values, the new values are captured, and pending ends at 1 (load wins).
- Underflow: frame retransmits the current hold contents; ufl pulses for 1 clk.
- Disable mid-frame: stops immediately (sck low, sd low). Re-enable always restarts at frame start; no partial frame resumes.
- Reset mid-frame: all state returns to reset values asynchronously.
- No combinational path from inputs to outputs.

Decomposition:
- Shared i2s package constants:
  - I2S_WIDTH = 16
  - I2S_SLOTS = 32
  - I2S_WS_LEFT = 0, I2S_WS_RIGHT = 1
  - slot-index width = 5
- Sub-module i2s_sck_gen (divider plus sck toggle, emitting a fall-event strobe). It is reusable by a future master-mode receiver.
- Slot counter, shifter and buffer stay in the top module.

Test Plan:
- DIV=2; load lft=0xA5F0, rgt=0x0F3C; enable -> xfc at clk 4.
  - sd on successive falls reads 1010_0101_1111_0000 then 0000_1111_0011_1100.
  - ws rises at slot 15 and falls at slot 31.
  - ufl = 0.
- Continue without a new load -> second xfc at clk 4+128; ufl pulses with it; the same 32 bits are repeated.
- Load 0x8001/0x7FFE in the same clk as a frame-start fall -> that frame sends the old data. The next frame sends 0x8001/0x7FFE with ufl = 0.
- Drop rf_i2so_en at slot 7, hold 10 clk, re-enable -> sck/ws/sd = 0 while disabled. Frame restarts at slot 0, with xfc 2*DIV clk after re-enable.
- Assert rst at slot 20 -> all outputs 0 in the same cycle. After release with en = 1 and no load, the first frame sends 0x0000/0x0000 with ufl = 1.
- DIV=1 -> sck toggles every clk; frame = 64 clk; bit order and ws alignment identical to DIV=2.
